fpu_align_pipe: RTL and testbench

- Parametrised, registered successor to the combinational add/sub alignment stage of the FPU.
- Takes two unpacked operands (sign, biased exponent, mantissa with hidden bit) plus the add/sub opcode.
- Produces swapped, aligned and conditionally inverted adder inputs with guard, round and sticky bits, the base exponent and the result sign.
- Two internal register stages with valid/ready flow control; sits between the unpack stage and the mantissa adder.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fpu_sticky_shifter.sv | 31 +++
 rtl/fpu_align_pipe.sv | 198 +++++++++++++++++++
 tb/tb_fpu_align_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants: derived operand widths, mantissa-compare encoding and add/sub opcodes.
// No logic; imported by the alignment pipeline and its shifter.
package fpu_pkg;

    // {gt, eq} encoding of the operand-1 versus operand-2 mantissa compare
    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_EQ = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b00;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int mantissa_size(input int fraction_size);
        return fraction_size + 1;
    endfunction

    // Mantissa plus guard, round and sticky
    function automatic int rounding_size(input int fraction_size);
        return mantissa_size(fraction_size) + 3;
    endfunction

    // Wide enough to hold the saturation value rounding_size itself
    function automatic int shift_size(input int fraction_size);
        return $clog2(rounding_size(fraction_size)) + 1;
    endfunction

endpackage

// File: rtl/fpu_sticky_shifter.sv
// Logical right shifter that ORs every bit shifted out into a sticky flag; saturates at Width.
// Latency: combinational. Backpressure: none, pure datapath.
module fpu_sticky_shifter #(
    parameter int Width      = 26,
    parameter int ShiftWidth = 6
) (
    input  logic [Width-1:0]      din,
    input  logic [ShiftWidth-1:0] shamt,
    output logic [Width-1:0]      dout,
    output logic                  sticky
);

    localparam logic [ShiftWidth-1:0] SatLimit = ShiftWidth'(Width);

    logic [Width-1:0] lost_mask;

    always_comb begin
        dout      = '0;
        sticky    = 1'b0;
        lost_mask = '0;
        if (shamt >= SatLimit) begin
            // Everything falls off the end; only the sticky survives
            sticky = |din;
        end else begin
            lost_mask = ~({Width{1'b1}} << shamt);
            dout      = din >> shamt;
            sticky    = |(din & lost_mask);
        end
    end

endmodule

// File: rtl/fpu_align_pipe.sv
// Add/sub alignment: swap, align with guard/round/sticky, invert the smaller operand on EffSub.
// Latency 2 cycles, 1/cycle; FPU_ALIGN_TAG_EN adds a TagSize tag carried in lockstep.
// Backpressure: combinational ready chain with no bubble; outputs hold while OutValid && !OutReady.
module fpu_align_pipe
    import fpu_pkg::*;
#(
    parameter  int ExponentSize = 8,
    parameter  int FractionSize = 23,
`ifdef FPU_ALIGN_TAG_EN
    parameter  int TagSize      = 4,
`endif
    localparam int MantissaSize = mantissa_size(FractionSize),
    localparam int RoundingSize = rounding_size(FractionSize),
    localparam int ShiftSize    = shift_size(FractionSize)
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    Op,
    input  logic                    Sign1,
    input  logic                    Sign2,
    input  logic [ExponentSize-1:0] Exponent1,
    input  logic [ExponentSize-1:0] Exponent2,
    input  logic [MantissaSize-1:0] Mantissa1,
    input  logic [MantissaSize-1:0] Mantissa2,
`ifdef FPU_ALIGN_TAG_EN
    input  logic [TagSize-1:0]      InTag,
    output logic [TagSize-1:0]      OutTag,
`endif
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [RoundingSize-1:0] Adder1,
    output logic [RoundingSize-1:0] Adder2,
    output logic                    CarryIn,
    output logic                    EffSub,
    output logic [ExponentSize-1:0] ExponentBase,
    output logic                    ResultSign
);

    localparam int PreAlignSize = MantissaSize + 2;
    localparam int WideSize     = ExponentSize + 1 + ShiftSize;
    localparam logic [WideSize-1:0] SatWide = WideSize'(RoundingSize);

    typedef struct packed {
        logic                    exp_swap;
        logic                    exp_eq;
        logic [1:0]              mcmp;
        logic [ShiftSize-1:0]    shift;
        logic [ExponentSize-1:0] exp_base;
        logic                    eff_sub;
        logic                    sign1;
        logic                    sign2_op;
        logic [MantissaSize-1:0] m1;
        logic [MantissaSize-1:0] m2;
    } s1_t;

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv  = !OutValid || OutReady;
    assign s1_adv  = !s1_valid || s2_adv;
    assign InReady = s1_adv;

    // ---------------- stage 1: exponent compare ----------------
    logic [ExponentSize:0] exp_diff;
    logic [ExponentSize:0] abs_diff;
    logic [WideSize-1:0]   abs_wide;
    logic                  shift_sat;
    logic                  op_sub;
    s1_t                   s1_d;
    s1_t                   s1_q;

    // MSB of the (ExponentSize+1)-bit difference is its sign
    assign exp_diff  = {1'b0, Exponent1} - {1'b0, Exponent2};
    assign abs_diff  = exp_diff[ExponentSize] ? -exp_diff : exp_diff;
    assign abs_wide  = {{ShiftSize{1'b0}}, abs_diff};
    assign shift_sat = (abs_wide >= SatWide);
    assign op_sub    = (Op == OP_SUB);

    always_comb begin
        s1_d          = '0;
        s1_d.exp_swap = exp_diff[ExponentSize];
        s1_d.exp_eq   = (Exponent1 == Exponent2);
        if (Mantissa1 > Mantissa2) begin
            s1_d.mcmp = CMP_GT;
        end else if (Mantissa1 == Mantissa2) begin
            s1_d.mcmp = CMP_EQ;
        end else begin
            s1_d.mcmp = CMP_LT;
        end
        s1_d.shift    = shift_sat ? ShiftSize'(RoundingSize) : abs_wide[ShiftSize-1:0];
        s1_d.exp_base = exp_diff[ExponentSize] ? Exponent2 : Exponent1;
        s1_d.eff_sub  = Sign1 ^ Sign2 ^ op_sub;
        s1_d.sign1    = Sign1;
        s1_d.sign2_op = Sign2 ^ op_sub;
        s1_d.m1       = Mantissa1;
        s1_d.m2       = Mantissa2;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= InValid;
            if (InValid) begin
                s1_q <= s1_d;
            end
        end
    end

    // ---------------- stage 2: align and invert ----------------
    logic                    swap;
    logic                    equal_mag;
    logic [MantissaSize-1:0] small_m;
    logic [MantissaSize-1:0] large_m;
    logic [PreAlignSize-1:0] pre_align;
    logic [PreAlignSize-1:0] shifted;
    logic                    sticky;
    logic [RoundingSize-1:0] aligned;
    logic [RoundingSize-1:0] adder1_d;
    logic [RoundingSize-1:0] adder2_d;
    logic                    result_sign_d;

    // Equal exponents fall back on the mantissa compare so Adder1 always carries the smaller magnitude
    assign swap      = s1_q.exp_swap || (s1_q.exp_eq && (s1_q.mcmp == CMP_LT));
    assign equal_mag = s1_q.exp_eq && (s1_q.mcmp == CMP_EQ);
    assign small_m   = swap ? s1_q.m1 : s1_q.m2;
    assign large_m   = swap ? s1_q.m2 : s1_q.m1;
    assign pre_align = {small_m, 2'b00};

    fpu_sticky_shifter #(
        .Width      (PreAlignSize),
        .ShiftWidth (ShiftSize)
    ) u_shifter (
        .din    (pre_align),
        .shamt  (s1_q.shift),
        .dout   (shifted),
        .sticky (sticky)
    );

    assign aligned  = {shifted, sticky};
    assign adder1_d = s1_q.eff_sub ? ~aligned : aligned;
    assign adder2_d = {large_m, 3'b000};

    always_comb begin
        result_sign_d = s1_q.sign1;
        if (s1_q.eff_sub && equal_mag) begin
            result_sign_d = 1'b0;
        end else if (swap) begin
            result_sign_d = s1_q.sign2_op;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutValid     <= 1'b0;
            Adder1       <= '0;
            Adder2       <= '0;
            CarryIn      <= 1'b0;
            EffSub       <= 1'b0;
            ExponentBase <= '0;
            ResultSign   <= 1'b0;
        end else if (s2_adv) begin
            OutValid <= s1_valid;
            if (s1_valid) begin
                Adder1       <= adder1_d;
                Adder2       <= adder2_d;
                CarryIn      <= s1_q.eff_sub;
                EffSub       <= s1_q.eff_sub;
                ExponentBase <= s1_q.exp_base;
                ResultSign   <= result_sign_d;
            end
        end
    end

`ifdef FPU_ALIGN_TAG_EN
    logic [TagSize-1:0] s1_tag;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_tag <= '0;
            OutTag <= '0;
        end else begin
            if (s1_adv && InValid) begin
                s1_tag <= InTag;
            end
            if (s2_adv && s1_valid) begin
                OutTag <= s1_tag;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_align_pipe.sv
// Directed bench for fpu_align_pipe: hand-computed vectors, stall/backpressure and async reset.
module tb_fpu_align_pipe;

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic        Op;
    logic        Sign1;
    logic        Sign2;
    logic [7:0]  Exponent1;
    logic [7:0]  Exponent2;
    logic [23:0] Mantissa1;
    logic [23:0] Mantissa2;
    logic        OutValid;
    logic        OutReady;
    logic [26:0] Adder1;
    logic [26:0] Adder2;
    logic        CarryIn;
    logic        EffSub;
    logic [7:0]  ExponentBase;
    logic        ResultSign;
`ifdef FPU_ALIGN_TAG_EN
    logic [3:0]  InTag;
    logic [3:0]  OutTag;
`endif

    fpu_align_pipe dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .InValid      (InValid),
        .InReady      (InReady),
        .Op           (Op),
        .Sign1        (Sign1),
        .Sign2        (Sign2),
        .Exponent1    (Exponent1),
        .Exponent2    (Exponent2),
        .Mantissa1    (Mantissa1),
        .Mantissa2    (Mantissa2),
`ifdef FPU_ALIGN_TAG_EN
        .InTag        (InTag),
        .OutTag       (OutTag),
`endif
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Adder1       (Adder1),
        .Adder2       (Adder2),
        .CarryIn      (CarryIn),
        .EffSub       (EffSub),
        .ExponentBase (ExponentBase),
        .ResultSign   (ResultSign)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        s1;
        logic        s2;
        logic        op;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [23:0] m1;
        logic [23:0] m2;
        logic [26:0] a1;
        logic [26:0] a2;
        logic        cin;
        logic        eff;
        logic [7:0]  eb;
        logic        rs;
    } vec_t;

    vec_t vt [0:10];
    int   vectors;
    int   miscompares;

    // Fields: s1 s2 op e1 e2 m1 m2 | Adder1 Adder2 CarryIn EffSub ExponentBase ResultSign
    task automatic load_vectors();
        vt[0]  = {1'b0, 1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 8'd127, 1'b0};
        vt[1]  = {1'b0, 1'b0, 1'b1, 8'd127, 8'd127, 24'hC00000, 24'h800000, 27'h3FFFFFF, 27'h6000000, 1'b1, 1'b1, 8'd127, 1'b0};
        vt[2]  = {1'b0, 1'b0, 1'b0, 8'd130, 8'd127, 24'hC00000, 24'h800001, 27'h0800001, 27'h6000000, 1'b0, 1'b0, 8'd130, 1'b0};
        vt[3]  = {1'b1, 1'b1, 1'b0, 8'd100, 8'd200, 24'h800000, 24'h800000, 27'h0000001, 27'h4000000, 1'b0, 1'b0, 8'd200, 1'b1};
        vt[4]  = {1'b0, 1'b0, 1'b1, 8'd127, 8'd127, 24'h800000, 24'hC00000, 27'h3FFFFFF, 27'h6000000, 1'b1, 1'b1, 8'd127, 1'b1};
        vt[5]  = {1'b1, 1'b1, 1'b1, 8'd127, 8'd127, 24'hA00000, 24'hA00000, 27'h2FFFFFF, 27'h5000000, 1'b1, 1'b1, 8'd127, 1'b0};
        vt[6]  = {1'b0, 1'b1, 1'b0, 8'd128, 8'd127, 24'h800000, 24'h800000, 27'h5FFFFFF, 27'h4000000, 1'b1, 1'b1, 8'd128, 1'b0};
        vt[7]  = {1'b0, 1'b0, 1'b0, 8'd153, 8'd127, 24'h800000, 24'h800000, 27'h0000001, 27'h4000000, 1'b0, 1'b0, 8'd153, 1'b0};
        vt[8]  = {1'b0, 1'b0, 1'b0, 8'd152, 8'd127, 24'h800000, 24'h800000, 27'h0000002, 27'h4000000, 1'b0, 1'b0, 8'd152, 1'b0};
        vt[9]  = {1'b0, 1'b0, 1'b0, 8'd154, 8'd127, 24'h800000, 24'h000001, 27'h0000001, 27'h4000000, 1'b0, 1'b0, 8'd154, 1'b0};
        vt[10] = {1'b0, 1'b0, 1'b0, 8'd0,   8'd255, 24'h400000, 24'hFFFFFF, 27'h0000001, 27'h7FFFFF8, 1'b0, 1'b0, 8'd255, 1'b0};
    endtask

    function automatic logic [64:0] exp_of(input int i);
        return {vt[i].a1, vt[i].a2, vt[i].cin, vt[i].eff, vt[i].eb, vt[i].rs};
    endfunction

    function automatic logic [64:0] observed();
        return {Adder1, Adder2, CarryIn, EffSub, ExponentBase, ResultSign};
    endfunction

    task automatic drive(input int i);
        Op        = vt[i].op;
        Sign1     = vt[i].s1;
        Sign2     = vt[i].s2;
        Exponent1 = vt[i].e1;
        Exponent2 = vt[i].e2;
        Mantissa1 = vt[i].m1;
        Mantissa2 = vt[i].m2;
`ifdef FPU_ALIGN_TAG_EN
        InTag     = 4'(i);
`endif
    endtask

    // Presents one vector with OutReady high; lat counts cycles from presentation to OutValid
    task automatic send_one(input int i, output int lat, output logic [64:0] got);
        @(negedge Clk);
        drive(i);
        InValid  = 1'b1;
        OutReady = 1'b1;
        lat = 0;
        do begin
            @(negedge Clk);
            InValid = 1'b0;
            lat++;
        end while (!OutValid && lat < 8);
        got = observed();
    endtask

    task automatic test_reset();
        Rst_n    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        drive(0);
        repeat (3) @(negedge Clk);
        vectors++;
        if ({OutValid, observed()} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0", {OutValid, observed()});
        end
        Rst_n = 1'b1;
        #1;
        vectors++;
        if ({InReady, OutValid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_ready: got InReady/OutValid=%b expected 10", {InReady, OutValid});
        end
    endtask

    task automatic test_vectors(input int first, input int last);
        int          lat;
        logic [64:0] got;
        for (int i = first; i <= last; i++) begin
            send_one(i, lat, got);
            vectors++;
            if (lat !== 2) begin
                miscompares++;
                $display("FAIL latency[%0d]: got %0d expected 2", i, lat);
            end
            vectors++;
            if (got !== exp_of(i)) begin
                miscompares++;
                $display("FAIL vector[%0d]: got %h expected %h", i, got, exp_of(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int ids [0:3];
        int sent;
        int recv;
        bit stalled_seen;
        ids = '{1, 2, 3, 5};
        sent = 0;
        recv = 0;
        stalled_seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge Clk);
            OutReady = !(cyc >= 2 && cyc <= 4);
            InValid  = (sent < 4);
            if (sent < 4) drive(ids[sent]);
            #1;
            if (InValid && !InReady && !stalled_seen) begin
                stalled_seen = 1'b1;
                vectors++;
                if (sent !== 2) begin
                    miscompares++;
                    $display("FAIL b2b_accepted_before_stall: got %0d expected 2", sent);
                end
            end
            if (OutValid && !OutReady && recv < 4) begin
                vectors++;
                if (observed() !== exp_of(ids[recv])) begin
                    miscompares++;
                    $display("FAIL b2b_hold[cyc %0d]: got %h expected %h", cyc, observed(), exp_of(ids[recv]));
                end
            end
            if (OutValid && OutReady) begin
                vectors++;
                if (recv >= 4) begin
                    miscompares++;
                    $display("FAIL b2b_extra_output: got output %0d expected only 4", recv + 1);
                end else if (observed() !== exp_of(ids[recv])) begin
                    miscompares++;
                    $display("FAIL b2b_order[%0d]: got %h expected %h", recv, observed(), exp_of(ids[recv]));
                end
`ifdef FPU_ALIGN_TAG_EN
                if (recv < 4) begin
                    vectors++;
                    if (OutTag !== 4'(ids[recv])) begin
                        miscompares++;
                        $display("FAIL b2b_tag[%0d]: got %0d expected %0d", recv, OutTag, ids[recv]);
                    end
                end
`endif
                recv++;
            end
            if (InValid && InReady) sent++;
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        vectors++;
        if (recv !== 4 || sent !== 4) begin
            miscompares++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d expected 4/4", sent, recv);
        end
        vectors++;
        if (!stalled_seen) begin
            miscompares++;
            $display("FAIL b2b_backpressure: got InReady never low expected low after 2 accepted");
        end
    endtask

    task automatic test_reset_midflight();
        int          lat;
        logic [64:0] got;
        @(negedge Clk);
        OutReady = 1'b0;
        InValid  = 1'b1;
        drive(0);
        @(negedge Clk);
        drive(6);
        @(negedge Clk);
        InValid = 1'b0;
        #1;
        vectors++;
        if ({OutValid, InReady} !== 2'b10) begin
            miscompares++;
            $display("FAIL midflight_full: got OutValid/InReady=%b expected 10", {OutValid, InReady});
        end
        Rst_n = 1'b0;
        #1;
        vectors++;
        if ({OutValid, observed()} !== 66'd0) begin
            miscompares++;
            $display("FAIL midflight_reset: got %h expected 0", {OutValid, observed()});
        end
        @(negedge Clk);
        Rst_n    = 1'b1;
        OutReady = 1'b1;
        send_one(4, lat, got);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL post_reset_latency: got %0d expected 2", lat);
        end
        vectors++;
        if (got !== exp_of(4)) begin
            miscompares++;
            $display("FAIL post_reset_vector: got %h expected %h", got, exp_of(4));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        load_vectors();
        test_reset();
        test_vectors(0, 6);
        test_vectors(7, 10);
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
